// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite subordinate with a bank of NUM_REGS read/write registers.
// Write address and write data are captured independently. The write commits
// once both are present, and one write may be outstanding at a time. Reads
// return data one cycle after the AR handshake and do not depend on the write
// path. Register contents are exported flat on regs_o, and wr_pulse_o strobes
// for one cycle, in the same cycle as the new register value.
//
// Ports:
//   aclk, aresetn          clock, asynchronous active-low reset
//   aw*/w*/b*              write address / data / response channels
//   ar*/r*                 read address / data channels
//   regs_o                 reg i at [i*W +: W], W = DATA_BYTES*8
//   wr_pulse_o             one-hot strobe for the register just written
module axi4_lite_reg_slave #(
  parameter int DATA_BYTES = 4,
  parameter int ADDR_BYTES = 1,
  parameter int NUM_REGS   = 16
) (
  input  logic                               aclk,
  input  logic                               aresetn,
  input  logic                               awvalid,
  output logic                               awready,
  input  logic [ADDR_BYTES*8-1:0]            awaddr,
  input  logic [2:0]                         awprot,
  input  logic                               wvalid,
  output logic                               wready,
  input  logic [DATA_BYTES*8-1:0]            wdata,
  input  logic [DATA_BYTES-1:0]              wstrb,
  output logic                               bvalid,
  input  logic                               bready,
  output logic [1:0]                         bresp,
  input  logic                               arvalid,
  output logic                               arready,
  input  logic [ADDR_BYTES*8-1:0]            araddr,
  input  logic [2:0]                         arprot,
  output logic                               rvalid,
  input  logic                               rready,
  output logic [DATA_BYTES*8-1:0]            rdata,
  output logic [1:0]                         rresp,
  output logic [NUM_REGS*DATA_BYTES*8-1:0]   regs_o,
  output logic [NUM_REGS-1:0]                wr_pulse_o
);

  localparam int W    = DATA_BYTES * 8;
  localparam int AW   = ADDR_BYTES * 8;
  localparam int OFFS = $clog2(DATA_BYTES);
  localparam int IW   = AW - OFFS;
  localparam int RW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  // When the register bank fills the whole address space, every index is valid.
  localparam bit ALL_IN = (IW < 31) && (NUM_REGS >= (1 << IW));

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic in_range(input logic [IW-1:0] idx);
    return ALL_IN ? 1'b1 : (idx < IW'(NUM_REGS));
  endfunction

  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic              arready_q, arready_d;
  logic              aw_held_q, aw_held_d;
  logic              w_held_q, w_held_d;
  logic [AW-1:0]     awaddr_q, awaddr_d;
  logic [W-1:0]      wdata_q, wdata_d;
  logic [DATA_BYTES-1:0] wstrb_q, wstrb_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              rvalid_q, rvalid_d;
  logic [W-1:0]      rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [W-1:0]      regs_q [NUM_REGS];
  logic [W-1:0]      regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;

  logic              aw_hs, w_hs, ar_hs, commit;
  logic [AW-1:0]     wr_addr;
  logic [W-1:0]      wr_data;
  logic [DATA_BYTES-1:0] wr_strb;
  logic [IW-1:0]     wr_idx, rd_idx;
  logic [RW-1:0]     wr_sel, rd_sel;
  logic              wr_in, rd_in;
  logic [W-1:0]      rd_word;

  assign aw_hs = awvalid & awready_q;
  assign w_hs  = wvalid & wready_q;
  assign ar_hs = arvalid & arready_q;

  // Use the held beat if one was captured earlier, otherwise the live bus.
  assign wr_addr = aw_held_q ? awaddr_q : awaddr;
  assign wr_data = w_held_q ? wdata_q : wdata;
  assign wr_strb = w_held_q ? wstrb_q : wstrb;
  assign commit  = (aw_held_q | aw_hs) & (w_held_q | w_hs);

  assign wr_idx = wr_addr[AW-1:OFFS];
  assign rd_idx = araddr[AW-1:OFFS];
  assign wr_sel = wr_idx[RW-1:0];
  assign rd_sel = rd_idx[RW-1:0];
  assign wr_in  = in_range(wr_idx);
  assign rd_in  = in_range(rd_idx);

  // Low address bits and the prot fields do not affect the decode.
  logic unused_ok;
  assign unused_ok = ^{awprot, arprot, wr_addr, araddr, wr_idx, rd_idx};

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_sel == RW'(i)) rd_word = regs_q[i];
    end
  end

  always_comb begin
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    regs_d     = regs_q;
    wr_pulse_d = '0;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = awaddr;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = wdata;
      wstrb_d  = wstrb;
    end

    // The readies are low while a response is pending, so a commit and a B
    // handshake can never happen on the same edge.
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      if (wr_in) begin
        bresp_d = RESP_OKAY;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (wr_sel == RW'(i)) begin
            wr_pulse_d[i] = 1'b1;
            for (int k = 0; k < DATA_BYTES; k++) begin
              if (wr_strb[k]) regs_d[i][k*8 +: 8] = wr_data[k*8 +: 8];
            end
          end
        end
      end else begin
        bresp_d = RESP_SLVERR;
      end
    end else if (bvalid_q && bready) begin
      bvalid_d = 1'b0;
    end

    // Checking bvalid_q as well keeps the readies low for one extra edge
    // after the B handshake.
    awready_d = !aw_held_d && !bvalid_d && !bvalid_q;
    wready_d  = !w_held_d && !bvalid_d && !bvalid_q;
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_in ? rd_word : '0;
      rresp_d  = rd_in ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid_q && rready) begin
      rvalid_d = 1'b0;
    end
    arready_d = !rvalid_d && !rvalid_q;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      arready_q  <= 1'b0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= 2'b00;
      wr_pulse_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      arready_q  <= arready_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      wr_pulse_q <= wr_pulse_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign awready    = awready_q;
  assign wready     = wready_q;
  assign arready    = arready_q;
  assign bvalid     = bvalid_q;
  assign bresp      = bresp_q;
  assign rvalid     = rvalid_q;
  assign rdata      = rdata_q;
  assign rresp      = rresp_q;
  assign wr_pulse_o = wr_pulse_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign regs_o[g*W +: W] = regs_q[g];
  end

endmodule

// File: doc/axi4_lite_reg_slave.md
Name: axi4_lite_reg_slave

Overview:
Synthesizable AXI4-Lite subordinate: the responder that answers the master BFM's write/read calls with a real register bank, so RTL designs get a bus-attached control/status register file. It terminates all five AXI4-Lite channels, decodes word addresses, applies byte strobes and returns OKAY/SLVERR. Register contents are exported as a flat vector for fabric logic.

Parameters:
DATA_BYTES, 4, data bus width in bytes (1, 2, 4 or 8)
ADDR_BYTES, 1, address bus width in bytes
NUM_REGS, 16, number of DATA_BYTES-wide registers (1..2^(ADDR_BYTES*8)/DATA_BYTES)

Ports:
aclk  in  1  clock; everything is sampled on the rising edge
aresetn  in  1  asynchronous active-low reset
awvalid  in  1  write address valid
awready  out  1  write address ready
awaddr  in  ADDR_BYTES*8  write byte address
awprot  in  3  ignored
wvalid  in  1  write data valid
wready  out  1  write data ready
wdata  in  DATA_BYTES*8  write data
wstrb  in  DATA_BYTES  byte enables
bvalid  out  1  write response valid
bready  in  1  write response ready
bresp  out  2  write response
arvalid  in  1  read address valid
arready  out  1  read address ready
araddr  in  ADDR_BYTES*8  read byte address
arprot  in  3  ignored
rvalid  out  1  read data valid
rready  in  1  read data ready
rdata  out  DATA_BYTES*8  read data
rresp  out  2  read response
regs_o  out  NUM_REGS*DATA_BYTES*8  register contents; reg i occupies bits [i*W +: W], W=DATA_BYTES*8
wr_pulse_o  out  NUM_REGS  one-cycle strobe per register, high on the edge the register is written

Behaviour:
- Reset (asynchronous, aresetn=0): all outputs and registers go to 0, including the readies. Readies rise on the first aclk edge after aresetn is sampled high.
- Decode: index = addr >> log2(DATA_BYTES); low address bits are ignored. In range when index < NUM_REGS.
- Write path: AW and W are captured independently, in either order or together.
  - awready=1 while no address is held and bvalid=0; AW handshake latches awaddr and drops awready.
  - wready follows the same rule for wdata/wstrb.
- Write commit happens on the edge after both AW and W are held (or the handshake edge itself, if both arrive together).
  - In range: each byte with wstrb[k]=1 is updated; other bytes are unchanged. wr_pulse_o[index] is 1 for that one cycle. bresp=2'b00.
  - Out of range: no register changes, no pulse, bresp=2'b10 (SLVERR).
- bvalid asserts on the cycle after commit and holds, with bresp stable, until bready=1. It deasserts on the bready edge; awready/wready reassert on the following edge. At most one write is outstanding.
- Read path (independent of the write path):
  - arready=1 while rvalid=0.
  - AR handshake registers rdata and rresp, and rvalid asserts next cycle (1-cycle latency). arready drops during that cycle.
  - In range: rdata = register value, rresp=2'b00.
  - Out of range: rdata=0, rresp=2'b10.
  - rvalid, rdata and rresp are held stable until rready=1. arready returns on the edge after the R handshake.
- Simultaneous read and write commit to the same register on one edge: read returns the pre-write value.
- wstrb=0 in range: OKAY response, no bytes change, wr_pulse_o still fires.
- Reset mid-transaction: all pending AW/W/B/R state is discarded immediately. No response is issued for the aborted transaction.
- awprot and arprot have no effect.

Test Plan:
- Reset: hold aresetn=0 for 5 cycles -> all outputs 0; awready/wready/arready=1 one edge after release.
- Write 32'hDEADBEEF to 8'hC4 with NUM_REGS=64, then read 8'hC4 -> bresp=00, wr_pulse_o[49] single cycle, rdata=32'hDEADBEEF, rresp=00, rvalid one cycle after AR handshake.
- Write 32'hCAFEFEED with wstrb=4'b0101 to 8'h04 holding 0 -> reg1=32'h00FE00ED.
- W presented 3 cycles before AW; bready held low 4 cycles -> bvalid held with stable bresp; no new AW/W accepted until after the B handshake.
- NUM_REGS=16, write and read 8'hC0 -> bresp=10, rresp=10, rdata=0, no register or pulse change.
- Read of 8'h08 accepted on the same edge that commits a write of 32'h12345678 to 8'h08 (old value 0) -> rdata=0; a subsequent read returns 32'h12345678. Assert aresetn=0 while bvalid=1 -> bvalid=0 immediately, no response after release.
